// File: rtl/pc_fetch_stage.sv
// Program counter fetch stage: IDLE/RUN/HALTED control, stall/step gating,
// branch/jump redirect with flush, halt detection and an accepted-advance counter.
module pc_fetch_stage #(
  parameter int ADDR_LENGTH  = 11,
  parameter int COUNT_LENGTH = 16
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_start,
  input  logic                    i_step_mode,
  input  logic                    i_step,
  input  logic                    i_stall,
  input  logic                    i_branch_taken,
  input  logic [ADDR_LENGTH-1:0]  i_branch_target,
  input  logic                    i_jump,
  input  logic [ADDR_LENGTH-1:0]  i_jump_target,
  input  logic                    i_halt_detected,
  output logic [ADDR_LENGTH-1:0]  o_pc,
  output logic [ADDR_LENGTH-1:0]  o_pc_plus_one,
  output logic                    o_valid,
  output logic                    o_flush,
  output logic                    o_halted,
  output logic [COUNT_LENGTH-1:0] o_advance_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [ADDR_LENGTH-1:0]  PC_ONE  = {{(ADDR_LENGTH-1){1'b0}}, 1'b1};
  localparam logic [COUNT_LENGTH-1:0] CNT_ONE = {{(COUNT_LENGTH-1){1'b0}}, 1'b1};

  state_t                  state_q, state_d;
  logic [ADDR_LENGTH-1:0]  pc_q, pc_d;
  logic [COUNT_LENGTH-1:0] count_q, count_d;

  logic                    adv;
  logic                    redirect;
  logic                    halt_event;
  logic [ADDR_LENGTH-1:0]  pc_inc;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    pc_inc     = pc_q + PC_ONE;
    adv        = (state_q == RUN) && !i_stall && (!i_step_mode || i_step);
    redirect   = i_branch_taken || i_jump;
    // A redirect in the same cycle wins over a HALT at the current PC.
    halt_event = adv && i_halt_detected && !redirect;

    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;

    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (halt_event) begin
          state_d = HALTED;
        end else if (adv) begin
          count_d = count_q + CNT_ONE;
          if (i_branch_taken) begin
            pc_d = i_branch_target;
          end else if (i_jump) begin
            pc_d = i_jump_target;
          end else begin
            pc_d = pc_inc;
          end
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    o_pc            = pc_q;
    o_pc_plus_one   = pc_inc;
    o_valid         = (state_q == RUN) && !i_stall;
    o_flush         = adv && redirect;
    o_halted        = (state_q == HALTED);
    o_advance_count = count_q;
  end

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Self-checking bench for pc_fetch_stage: vector table, directed corner sequences
// and randomized traffic against a behavioural model.
module tb_pc_fetch_stage;

  localparam int AW = 11;
  localparam int CW = 16;
  localparam int unsigned PC_MOD  = 1 << AW;
  localparam int unsigned CNT_MOD = 1 << CW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, step_mode, step, stall, br, jmp, halt;
  logic [AW-1:0] br_tgt, jmp_tgt;
  logic [AW-1:0] pc, pc_p1;
  logic          valid, flush, halted;
  logic [CW-1:0] cnt;

  pc_fetch_stage #(
    .ADDR_LENGTH (AW),
    .COUNT_LENGTH(CW)
  ) dut (
    .i_clock        (clk),
    .i_reset        (rst_n),
    .i_start        (start),
    .i_step_mode    (step_mode),
    .i_step         (step),
    .i_stall        (stall),
    .i_branch_taken (br),
    .i_branch_target(br_tgt),
    .i_jump         (jmp),
    .i_jump_target  (jmp_tgt),
    .i_halt_detected(halt),
    .o_pc           (pc),
    .o_pc_plus_one  (pc_p1),
    .o_valid        (valid),
    .o_flush        (flush),
    .o_halted       (halted),
    .o_advance_count(cnt)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Behavioural model: fetching/halted flags, PC and count as plain integers.
  bit          m_fetching, m_halted;
  int unsigned m_pc, m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_fetching = 1'b0;
    m_halted   = 1'b0;
    m_pc       = 0;
    m_cnt      = 0;
  endtask

  task automatic drive(input bit st, sm, sp, stl, bt, input logic [AW-1:0] btg,
                       input bit j, input logic [AW-1:0] jtg, input bit h);
    start = st; step_mode = sm; step = sp; stall = stl;
    br = bt; br_tgt = btg; jmp = j; jmp_tgt = jtg; halt = h;
  endtask

  // One clock: drive at negedge, check combinational outputs, then registered ones after the edge.
  task automatic do_cycle(input bit st, sm, sp, stl, bt, input logic [AW-1:0] btg,
                          input bit j, input logic [AW-1:0] jtg, input bit h,
                          output bit c_valid, output bit c_flush);
    bit may_move;
    @(negedge clk);
    drive(st, sm, sp, stl, bt, btg, j, jtg, h);
    #1;
    may_move = m_fetching && !stl && (!sm || sp);
    c_valid  = valid;
    c_flush  = flush;
    check("valid", {31'd0, valid}, {31'd0, m_fetching && !stl});
    check("flush", {31'd0, flush}, {31'd0, may_move && (bt || j)});
    check("pc_plus_one", {21'd0, pc_p1}, (m_pc + 1) % PC_MOD);
    @(posedge clk);
    if (!m_fetching && !m_halted) begin
      if (st) m_fetching = 1'b1;
    end else if (may_move) begin
      if (bt) begin
        m_pc = btg; m_cnt = (m_cnt + 1) % CNT_MOD;
      end else if (j) begin
        m_pc = jtg; m_cnt = (m_cnt + 1) % CNT_MOD;
      end else if (h) begin
        m_fetching = 1'b0; m_halted = 1'b1;
      end else begin
        m_pc = (m_pc + 1) % PC_MOD; m_cnt = (m_cnt + 1) % CNT_MOD;
      end
    end
    #1;
    check("pc", {21'd0, pc}, m_pc);
    check("halted", {31'd0, halted}, {31'd0, m_halted});
    check("count", {16'd0, cnt}, m_cnt);
  endtask

  task automatic run_cycle(input bit st);
    bit v, f;
    do_cycle(st, 0, 0, 0, 0, '0, 0, '0, 0, v, f);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    drive(0, 0, 0, 0, 0, '0, 0, '0, 0);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_pc", {21'd0, pc}, 32'd0);
    check("rst_count", {16'd0, cnt}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit            st, sm, sp, stl, bt;
    logic [AW-1:0] btg;
    bit            j;
    logic [AW-1:0] jtg;
    bit            h;
    logic [AW-1:0] e_pc;
    bit            e_flush, e_valid;
    logic [CW-1:0] e_cnt;
  } vec_t;

  vec_t tbl[11];

  function automatic vec_t mk(bit st, bit stl, bit bt, logic [AW-1:0] btg, bit j,
                              logic [AW-1:0] jtg, bit h, logic [AW-1:0] e_pc,
                              bit e_flush, bit e_valid, logic [CW-1:0] e_cnt);
    vec_t v;
    v.st = st; v.sm = 1'b0; v.sp = 1'b0; v.stl = stl; v.bt = bt; v.btg = btg;
    v.j = j; v.jtg = jtg; v.h = h; v.e_pc = e_pc; v.e_flush = e_flush;
    v.e_valid = e_valid; v.e_cnt = e_cnt;
    return v;
  endfunction

  initial begin
    bit v, f;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, '0, 0, '0, 0);
    model_reset();

    // Start, 5 sequential fetches, stalled branch, branch-over-jump, jump-over-halt.
    tbl[0]  = mk(1, 0, 0, 11'h000, 0, 11'h000, 0, 11'h000, 0, 0, 16'd0);
    tbl[1]  = mk(0, 0, 0, 11'h000, 0, 11'h000, 0, 11'h001, 0, 1, 16'd1);
    tbl[2]  = mk(0, 0, 0, 11'h000, 0, 11'h000, 0, 11'h002, 0, 1, 16'd2);
    tbl[3]  = mk(0, 0, 0, 11'h000, 0, 11'h000, 0, 11'h003, 0, 1, 16'd3);
    tbl[4]  = mk(0, 0, 0, 11'h000, 0, 11'h000, 0, 11'h004, 0, 1, 16'd4);
    tbl[5]  = mk(0, 0, 0, 11'h000, 0, 11'h000, 0, 11'h005, 0, 1, 16'd5);
    tbl[6]  = mk(0, 1, 1, 11'h7F0, 0, 11'h000, 0, 11'h005, 0, 0, 16'd5);
    tbl[7]  = mk(0, 1, 1, 11'h7F0, 0, 11'h000, 0, 11'h005, 0, 0, 16'd5);
    tbl[8]  = mk(0, 0, 1, 11'h7F0, 1, 11'h010, 0, 11'h7F0, 1, 1, 16'd6);
    tbl[9]  = mk(0, 0, 0, 11'h000, 1, 11'h010, 1, 11'h010, 1, 1, 16'd7);
    tbl[10] = mk(0, 0, 0, 11'h000, 0, 11'h000, 0, 11'h011, 0, 1, 16'd8);

    apply_reset();
    for (int unsigned i = 0; i < 11; i++) begin
      do_cycle(tbl[i].st, tbl[i].sm, tbl[i].sp, tbl[i].stl, tbl[i].bt, tbl[i].btg,
               tbl[i].j, tbl[i].jtg, tbl[i].h, v, f);
      check($sformatf("tbl%0d_pc", i), {21'd0, pc}, {21'd0, tbl[i].e_pc});
      check($sformatf("tbl%0d_flush", i), {31'd0, f}, {31'd0, tbl[i].e_flush});
      check($sformatf("tbl%0d_valid", i), {31'd0, v}, {31'd0, tbl[i].e_valid});
      check($sformatf("tbl%0d_count", i), {16'd0, cnt}, {16'd0, tbl[i].e_cnt});
    end

    // Step mode: two pulses in six cycles, then the top-of-memory wrap.
    apply_reset();
    run_cycle(1);
    for (int unsigned i = 0; i < 6; i++)
      do_cycle(0, 1, (i == 1 || i == 4), 0, 0, '0, 0, '0, 0, v, f);
    check("step_pc", {21'd0, pc}, 32'd2);
    do_cycle(0, 1, 1, 0, 0, '0, 1, 11'h7FF, 0, v, f);
    check("step_jump_pc", {21'd0, pc}, 32'h7FF);
    do_cycle(0, 1, 1, 0, 0, '0, 0, '0, 0, v, f);
    check("wrap_pc", {21'd0, pc}, 32'd0);

    // Halt at PC 9; start afterwards is ignored.
    apply_reset();
    run_cycle(1);
    for (int unsigned i = 0; i < 9; i++) run_cycle(0);
    do_cycle(0, 0, 0, 0, 0, '0, 0, '0, 1, v, f);
    check("halt_pc", {21'd0, pc}, 32'd9);
    check("halt_flag", {31'd0, halted}, 32'd1);
    for (int unsigned i = 0; i < 3; i++) begin
      do_cycle(1, 0, 0, 0, 0, '0, 0, '0, 0, v, f);
      check("halted_valid", {31'd0, v}, 32'd0);
      check("halted_pc", {21'd0, pc}, 32'd9);
    end

    // Asynchronous reset mid-RUN at PC 12 while a branch is presented.
    apply_reset();
    run_cycle(1);
    for (int unsigned i = 0; i < 12; i++) run_cycle(0);
    check("pre_rst_pc", {21'd0, pc}, 32'd12);
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 11'h123, 0, '0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_pc", {21'd0, pc}, 32'd0);
    check("async_count", {16'd0, cnt}, 32'd0);
    check("async_halted", {31'd0, halted}, 32'd0);
    check("async_flush", {31'd0, flush}, 32'd0);
    check("async_valid", {31'd0, valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int unsigned i = 0; i < 3; i++) run_cycle(0);
    check("idle_pc", {21'd0, pc}, 32'd0);
    run_cycle(1);
    run_cycle(0);
    check("restart_pc", {21'd0, pc}, 32'd1);

    // Randomized traffic against the model.
    apply_reset();
    for (int unsigned i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0 || (m_halted && $urandom_range(0, 7) == 0)) begin
        apply_reset();
      end else begin
        do_cycle($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, AW'($urandom),
                 $urandom_range(0, 5) == 0, AW'($urandom), $urandom_range(0, 29) == 0, v, f);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pc_fetch_stage.md
PC_FETCH_STAGE -- requirements
Module: pc_fetch_stage

Interface
REQ-001 The module SHALL have parameter ADDR_LENGTH, default 11, giving the width of the program counter and of all address ports.
REQ-002 The module SHALL have parameter COUNT_LENGTH, default 16, giving the width of the advance counter.
REQ-003 The module SHALL have port i_clock  input  1  the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port i_reset  input  1  reset, asynchronous, active-low.
REQ-005 The module SHALL have port i_start  input  1  begin fetching; leaves IDLE.
REQ-006 The module SHALL have port i_step_mode  input  1  1 = single-step operation, 0 = continuous.
REQ-007 The module SHALL have port i_step  input  1  one-cycle pulse that permits one advance in step mode.
REQ-008 The module SHALL have port i_stall  input  1  hazard stall; hold PC.
REQ-009 The module SHALL have port i_branch_taken  input  1  redirect to i_branch_target.
REQ-010 The module SHALL have port i_branch_target  input  ADDR_LENGTH  branch target from the signed branch adder.
REQ-011 The module SHALL have port i_jump  input  1  redirect to i_jump_target.
REQ-012 The module SHALL have port i_jump_target  input  ADDR_LENGTH  jump target.
REQ-013 The module SHALL have port i_halt_detected  input  1  instruction at o_pc is HALT.
REQ-014 The module SHALL have port o_pc  output  ADDR_LENGTH  current fetch address, registered.
REQ-015 The module SHALL have port o_pc_plus_one  output  ADDR_LENGTH  o_pc + 1 modulo 2^ADDR_LENGTH, combinational; feeds data_A of the branch adder.
REQ-016 The module SHALL have port o_valid  output  1  fetch at o_pc is valid this cycle.
REQ-017 The module SHALL have port o_flush  output  1  redirect accepted this cycle; IF/ID must be squashed.
REQ-018 The module SHALL have port o_halted  output  1  state is HALTED.
REQ-019 The module SHALL have port o_advance_count  output  COUNT_LENGTH  number of accepted PC updates since reset.

Function
REQ-020 The module SHALL implement states IDLE, RUN, HALTED.
REQ-021 The transitions SHALL be: IDLE->RUN when i_start=1; RUN->HALTED on a halt event (REQ-025); HALTED holds until reset; i_start is ignored outside IDLE.
REQ-022 The advance permit "adv" SHALL be: state=RUN and i_stall=0 and (i_step_mode=0 or i_step=1).
REQ-023 When adv=1, the next PC SHALL be selected with priority: i_branch_taken -> i_branch_target; else i_jump -> i_jump_target; else o_pc_plus_one.
REQ-024 When adv=0, the PC SHALL hold, and i_branch_taken/i_jump SHALL be ignored (a stall defers the redirect; upstream must hold it).
REQ-025 A halt event SHALL be adv=1 and i_halt_detected=1 and i_branch_taken=0 and i_jump=0; the PC SHALL then hold at the HALT address and state SHALL go to HALTED.
REQ-026 A redirect SHALL beat i_halt_detected in the same cycle: the PC takes the target and no halt occurs.
REQ-027 o_flush SHALL be 1 exactly in cycles where adv=1 and (i_branch_taken or i_jump), combinationally.
REQ-028 o_valid SHALL be 1 when state=RUN and i_stall=0, and 0 in IDLE and HALTED.
REQ-029 PC increment SHALL wrap: 2^ADDR_LENGTH-1 + 1 -> 0; targets SHALL be loaded unmodified.
REQ-030 o_advance_count SHALL increment by 1 on every accepted PC update (sequential or redirect), not on halt events, and SHALL wrap at 2^COUNT_LENGTH.
REQ-031 The PC update latency SHALL be one clock: o_pc shows the new value in the cycle after adv=1.

Reset
REQ-032 i_reset=0 SHALL immediately, without a clock, force o_pc=0, state=IDLE, o_advance_count=0, o_halted=0, o_valid=0, o_flush=0.
REQ-033 A reset asserted mid-RUN or in HALTED SHALL discard all state; after release, the module SHALL wait in IDLE for i_start.

Verification
REQ-034 The bench SHALL check: reset, i_start=1 for 1 cycle, continuous mode, 4 clocks -> o_pc 0,1,2,3,4; o_advance_count=4; o_valid=1.
REQ-035 The bench SHALL check: PC=5, i_branch_taken=1, target=0x7F0, i_jump=1, target=0x010 -> o_flush=1 that cycle; next o_pc=0x7F0.
REQ-036 The bench SHALL check: PC=5, i_stall=1 with i_branch_taken=1 for 2 cycles -> o_pc stays 5, o_flush=0, o_valid=0, count unchanged.
REQ-037 The bench SHALL check: step mode, i_step pulsed twice over 6 cycles from PC=0 -> o_pc=2 at end; PC=0x7FF advance -> o_pc=0.
REQ-038 The bench SHALL check: PC=9, i_halt_detected=1 -> o_pc holds 9, o_halted=1 next cycle, o_valid=0; later i_start has no effect.
REQ-039 The bench SHALL check: i_reset pulsed low between clock edges while PC=12 in RUN -> o_pc=0, o_halted=0, count=0 immediately; no advance until i_start.
